// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- two-requester memory arbiter and transaction sequencer.
//
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// Only one transaction is in flight at a time. Round-robin arbitration is used
// when both requesters ask in the same IDLE cycle. A response timeout turns a
// stalled memory into an error response.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (byte mask is DATA_W/8 bits)
//   TIMEOUT  max RESP cycles to wait for i_mem_rvalid; 0 disables the timeout
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_ifu_req/addr                 IFU read request (held until o_ifu_gnt)
//   o_ifu_gnt/rvalid/rdata         IFU accept pulse, response pulse, read data
//   i_lsu_req/addr/wen/wdata/wmask LSU request (held until o_lsu_gnt)
//   o_lsu_gnt/rvalid/rdata         LSU accept pulse, response/write-ack, data
//   o_mem_valid/addr/wen/wdata/wmask  request towards memory
//   i_mem_ready                    memory accepts the request
//   i_mem_rvalid/rdata             memory response
//   o_busy                         transaction in progress
//   o_err                          timeout pulse
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_ifu_req,
  input  logic [ADDR_W-1:0]     i_ifu_addr,
  output logic                  o_ifu_gnt,
  output logic                  o_ifu_rvalid,
  output logic [DATA_W-1:0]     o_ifu_rdata,

  input  logic                  i_lsu_req,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wmask,
  output logic                  o_lsu_gnt,
  output logic                  o_lsu_rvalid,
  output logic [DATA_W-1:0]     o_lsu_rdata,

  output logic                  o_mem_valid,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_wen,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wmask,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata,

  output logic                  o_busy,
  output logic                  o_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN  = (TIMEOUT != 0);
  // Counter value on the last RESP cycle before the timeout fires; the counter
  // is 0 on the first RESP cycle, so the error lands on RESP cycle TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t              r_state;
  // Owner of the current transaction; it also remembers the last grant, which
  // is exactly what round-robin needs on the next conflict.
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_nxt;
  logic                w_any_req;
  logic                w_pick_lsu;
  logic                w_grant;
  logic                w_resp;
  logic                w_timeout;
  logic                w_live;

  assign w_any_req  = i_ifu_req | i_lsu_req;
  // LSU wins when it is alone, or when both ask and the IFU had the last turn.
  assign w_pick_lsu = i_lsu_req & (~i_ifu_req | (r_owner == OWN_IFU));

  // ---------------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_resp      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (i_mem_ready) begin
          w_grant     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // A real response beats a coincident timeout.
        if (i_mem_rvalid) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_resp      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      r_state <= S_IDLE;
      r_owner <= OWN_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && w_any_req) begin
        if (w_pick_lsu) begin
          r_owner <= OWN_LSU;
          r_addr  <= i_lsu_addr;
          r_wen   <= i_lsu_wen;
          r_wdata <= i_lsu_wdata;
          r_wmask <= i_lsu_wmask;
        end else begin
          // Fetches are always reads with no write payload.
          r_owner <= OWN_IFU;
          r_addr  <= i_ifu_addr;
          r_wen   <= 1'b0;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end

      if (w_grant) begin
        r_cnt <= '0;
      end else if (r_state == S_RESP) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake outputs are suppressed while reset is asserted so a transaction
  // interrupted by reset never produces a grant or a response.
  assign w_live = ~i_rst;

  assign o_mem_valid  = w_live & (r_state == S_REQ);
  assign o_mem_addr   = r_addr;
  assign o_mem_wen    = r_wen;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_wmask  = r_wmask;

  assign o_ifu_gnt    = w_live & w_grant & (r_owner == OWN_IFU);
  assign o_lsu_gnt    = w_live & w_grant & (r_owner == OWN_LSU);

  assign o_ifu_rvalid = w_live & w_resp & (r_owner == OWN_IFU);
  assign o_lsu_rvalid = w_live & w_resp & (r_owner == OWN_LSU);

  // Data passes through only on a genuine response; a timeout returns zero.
  assign o_ifu_rdata  = (o_ifu_rvalid & ~w_timeout) ? i_mem_rdata : '0;
  assign o_lsu_rdata  = (o_lsu_rvalid & ~w_timeout) ? i_mem_rdata : '0;

  assign o_err        = w_live & w_timeout;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb -- self-checking bench for mem_arb (TIMEOUT = 4).
//
// A table of transaction records is replayed through a cycle-accurate driver
// that plays the memory side. Expected responses are queued at grant time and
// compared by a monitor when the DUT raises rvalid. Reset-in-flight and the
// post-reset conflict order are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_arb;

  localparam int TO = 4;

  logic        clk;
  logic        i_rst;
  logic        i_ifu_req;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_gnt;
  logic        o_ifu_rvalid;
  logic [31:0] o_ifu_rdata;
  logic        i_lsu_req;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic        o_lsu_gnt;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_err;

  mem_arb #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_ifu_req    (i_ifu_req),
    .i_ifu_addr   (i_ifu_addr),
    .o_ifu_gnt    (o_ifu_gnt),
    .o_ifu_rvalid (o_ifu_rvalid),
    .o_ifu_rdata  (o_ifu_rdata),
    .i_lsu_req    (i_lsu_req),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wen    (i_lsu_wen),
    .i_lsu_wdata  (i_lsu_wdata),
    .i_lsu_wmask  (i_lsu_wmask),
    .o_lsu_gnt    (o_lsu_gnt),
    .o_lsu_rvalid (o_lsu_rvalid),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_mem_valid  (o_mem_valid),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One transaction record: requester inputs, memory behaviour, expectations.
  // rvalid_dly >= TO means the memory never answers.
  typedef struct {
    logic        ifu_req;
    logic        lsu_req;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    int          ready_dly;
    int          rvalid_dly;
    logic [31:0] rdata;
    logic        exp_lsu;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];

  function automatic vec_t mk(input logic ir, input logic lr,
                              input logic [31:0] ia, input logic [31:0] la,
                              input logic lw, input logic [31:0] lwd, input logic [3:0] lwm,
                              input int rd, input int vd, input logic [31:0] dat,
                              input logic el, input logic ee);
    vec_t v;
    v.ifu_req = ir;  v.lsu_req = lr;
    v.ifu_addr = ia; v.lsu_addr = la;
    v.lsu_wen = lw;  v.lsu_wdata = lwd; v.lsu_wmask = lwm;
    v.ready_dly = rd; v.rvalid_dly = vd; v.rdata = dat;
    v.exp_lsu = el;  v.exp_err = ee;
    return v;
  endfunction

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_ifu_rvalid || o_lsu_rvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        check("resp_owner_lsu", o_lsu_rvalid, e.lsu);
        check("resp_rdata", o_lsu_rvalid ? o_lsu_rdata : o_ifu_rdata, e.rdata);
        check("resp_err", o_err, e.err);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int          resp_k;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    resp_k  = (v.rvalid_dly < TO) ? v.rvalid_dly : TO - 1;
    e_addr  = v.exp_lsu ? v.lsu_addr  : v.ifu_addr;
    e_wen   = v.exp_lsu ? v.lsu_wen   : 1'b0;
    e_wdata = v.exp_lsu ? v.lsu_wdata : 32'h0;
    e_wmask = v.exp_lsu ? v.lsu_wmask : 4'h0;

    // IDLE cycle: present the requests.
    @(posedge clk); #1;
    i_ifu_req    = v.ifu_req;
    i_ifu_addr   = v.ifu_addr;
    i_lsu_req    = v.lsu_req;
    i_lsu_addr   = v.lsu_addr;
    i_lsu_wen    = v.lsu_wen;
    i_lsu_wdata  = v.lsu_wdata;
    i_lsu_wmask  = v.lsu_wmask;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, o_busy, 1'b0);
    check({tag, "_idle_valid"}, o_mem_valid, 1'b0);

    // REQ cycles: memory accepts after ready_dly stall cycles.
    for (int d = 0; d <= v.ready_dly; d++) begin
      @(posedge clk); #1;
      i_mem_ready = (d == v.ready_dly);
      @(negedge clk);
      check({tag, "_mem_valid"}, o_mem_valid, 1'b1);
      check({tag, "_mem_addr"},  o_mem_addr,  e_addr);
      check({tag, "_mem_wen"},   o_mem_wen,   e_wen);
      check({tag, "_mem_wdata"}, o_mem_wdata, e_wdata);
      check({tag, "_mem_wmask"}, o_mem_wmask, e_wmask);
      check({tag, "_ifu_gnt"},   o_ifu_gnt,   (!v.exp_lsu) && (d == v.ready_dly));
      check({tag, "_lsu_gnt"},   o_lsu_gnt,   v.exp_lsu && (d == v.ready_dly));
      if (d == v.ready_dly) begin
        resp_t e;
        e.lsu   = v.exp_lsu;
        e.rdata = v.exp_err ? 32'h0 : v.rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
      end
    end

    // RESP cycles: owner drops its request; the loser keeps holding.
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    if (v.exp_lsu) i_lsu_req = 1'b0;
    else           i_ifu_req = 1'b0;
    for (int k = 0; k <= resp_k; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      i_mem_rvalid = (k == v.rvalid_dly);
      i_mem_rdata  = (k == v.rvalid_dly) ? v.rdata : (32'hBAD0_0000 | 32'(k));
      @(negedge clk);
      check({tag, "_resp_valid"},  o_mem_valid,  1'b0);
      check({tag, "_resp_busy"},   o_busy,       1'b1);
      check({tag, "_ifu_rvalid"},  o_ifu_rvalid, (!v.exp_lsu) && (k == resp_k));
      check({tag, "_lsu_rvalid"},  o_lsu_rvalid, v.exp_lsu && (k == resp_k));
      check({tag, "_err"},         o_err,        v.exp_err && (k == resp_k));
      check({tag, "_other_rdata"}, v.exp_lsu ? o_ifu_rdata : o_lsu_rdata, 32'h0);
    end
  endtask

  vec_t vecs[11];
  vec_t cvecs[4];

  initial begin
    // Watchdog: the run is a few hundred cycles; anything longer is a hang.
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                ifu   lsu   ifu_addr      lsu_addr      wen   wdata         wmask rdy vld rdata         lsu   err
    vecs[0]  = mk(1'b1, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 32'h0,        4'h0, 0, 0, 32'h0000_0413, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h0,        32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h0,        1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 32'h8000_0010, 32'h8000_2000, 1'b0, 32'h0,        4'h0, 0, 1, 32'h1111_2222, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 32'h8000_0014, 32'h8000_2000, 1'b0, 32'h0,        4'h0, 1, 0, 32'h3333_4444, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 32'h8000_0014, 32'h8000_2004, 1'b1, 32'h5555_AAAA, 4'h3, 0, 2, 32'h6666_7777, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 32'h0,        32'h8000_2004, 1'b1, 32'h5555_AAAA, 4'h3, 2, 1, 32'h0,        1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h8000_0018, 32'h0,        1'b0, 32'h0,        4'h0, 0, 3, 32'h8888_9999, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h0,        32'h8000_3000, 1'b0, 32'h0,        4'h0, 0, 9, 32'hCAFE_F00D, 1'b1, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 32'h8000_001C, 32'h0,        1'b0, 32'h0,        4'h0, 1, 2, 32'hABCD_0123, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h8000_0020, 32'h8000_3004, 1'b0, 32'h0,        4'h0, 0, 0, 32'h1357_9BDF, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 32'h8000_0020, 32'h0,        1'b0, 32'h0,        4'h0, 0, 7, 32'h2468_ACE0, 1'b0, 1'b1);

    // Continuous conflict right after reset: LSU, IFU, LSU, IFU.
    cvecs[0] = mk(1'b1, 1'b1, 32'h8000_0100, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA0A0_0001, 1'b1, 1'b0);
    cvecs[1] = mk(1'b1, 1'b1, 32'h8000_0100, 32'h8000_4004, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA0A0_0002, 1'b0, 1'b0);
    cvecs[2] = mk(1'b1, 1'b1, 32'h8000_0104, 32'h8000_4004, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA0A0_0003, 1'b1, 1'b0);
    cvecs[3] = mk(1'b1, 1'b1, 32'h8000_0104, 32'h8000_4008, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA0A0_0004, 1'b0, 1'b0);

    i_rst        = 1'b1;
    i_ifu_req    = 1'b0;
    i_ifu_addr   = 32'h0;
    i_lsu_req    = 1'b0;
    i_lsu_addr   = 32'h0;
    i_lsu_wen    = 1'b0;
    i_lsu_wdata  = 32'h0;
    i_lsu_wmask  = 4'h0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_busy",      o_busy,      1'b0);
    check("rst_mem_valid", o_mem_valid, 1'b0);
    check("rst_mem_addr",  o_mem_addr,  32'h0);
    check("rst_mem_wen",   o_mem_wen,   1'b0);
    check("rst_mem_wmask", o_mem_wmask, 4'h0);
    check("rst_gnts",      {o_ifu_gnt, o_lsu_gnt}, 2'b00);
    check("rst_rvalids",   {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
    check("rst_err",       o_err,       1'b0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while waiting in RESP.
    @(posedge clk); #1;
    i_ifu_req    = 1'b1;
    i_ifu_addr   = 32'h8000_0040;
    i_lsu_req    = 1'b0;
    i_mem_rvalid = 1'b0;
    @(posedge clk); #1;
    i_mem_ready = 1'b1;
    @(negedge clk);
    check("mid_gnt", o_ifu_gnt, 1'b1);
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    i_ifu_req   = 1'b0;
    @(negedge clk);
    check("mid_resp_busy", o_busy, 1'b1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst        = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h7777_0000;
    i_mem_ready  = 1'b1;
    @(negedge clk);
    check("post_rst_busy",    o_busy,      1'b0);
    check("post_rst_valid",   o_mem_valid, 1'b0);
    check("post_rst_addr",    o_mem_addr,  32'h0);
    check("post_rst_wdata",   o_mem_wdata, 32'h0);
    check("post_rst_rvalids", {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
    check("post_rst_rdata",   {o_ifu_rdata, o_lsu_rdata}, 64'h0);
    check("post_rst_gnts",    {o_ifu_gnt, o_lsu_gnt}, 2'b00);
    check("post_rst_err",     o_err,       1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_rvalid_ignored", {o_ifu_rvalid, o_lsu_rvalid}, 2'b00);
    check("idle_ready_ignored",  {o_ifu_gnt, o_lsu_gnt}, 2'b00);
    check("idle_busy",           o_busy, 1'b0);
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    i_mem_ready  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_vec(cvecs[i], $sformatf("c%0d", i));
    end

    @(posedge clk); #1;
    i_ifu_req    = 1'b0;
    i_lsu_req    = 1'b0;
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    check("final_busy", o_busy, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester memory arbiter and transaction sequencer that shares the single memory port between instruction fetch (IFU) and load/store (LSU). It sits between `ifu`/LSU and the memory model or SRAM bridge, so a multi-cycle CPU can fetch and access data through one port. Conflicts are resolved round-robin. The block carries one outstanding transaction at a time and has a response timeout.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; mask width is `DATA_W/8`.
- `TIMEOUT`, 255, maximum cycles to wait for a response; 0 disables the timeout. Counter width is `$clog2(TIMEOUT+1)`, minimum 1.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_ifu_req`  in  1  IFU request; held stable until `o_ifu_gnt`.
- `i_ifu_addr`  in  ADDR_W  IFU address; always a read.
- `o_ifu_gnt`  out  1  IFU request accepted by memory (1-cycle pulse).
- `o_ifu_rvalid`  out  1  IFU response valid (1-cycle pulse).
- `o_ifu_rdata`  out  DATA_W  IFU read data.
- `i_lsu_req`  in  1  LSU request; held stable until `o_lsu_gnt`.
- `i_lsu_addr`  in  ADDR_W  LSU address.
- `i_lsu_wen`  in  1  1 = write, 0 = read.
- `i_lsu_wdata`  in  DATA_W  write data.
- `i_lsu_wmask`  in  DATA_W/8  byte write enables.
- `o_lsu_gnt`  out  1  LSU accepted pulse.
- `o_lsu_rvalid`  out  1  LSU response pulse; also the write acknowledge.
- `o_lsu_rdata`  out  DATA_W  LSU read data.
- `o_mem_valid`  out  1  memory request valid.
- `o_mem_addr`  out  ADDR_W  memory address.
- `o_mem_wen`  out  1  write enable.
- `o_mem_wdata`  out  DATA_W  write data.
- `o_mem_wmask`  out  DATA_W/8  byte mask.
- `i_mem_ready`  in  1  memory accepts request.
- `i_mem_rvalid`  in  1  memory response valid.
- `i_mem_rdata`  in  DATA_W  memory read data.
- `o_busy`  out  1  transaction in progress (state ≠ IDLE).
- `o_err`  out  1  timeout pulse.

## Operation
- States: IDLE, REQ, RESP.
- **IDLE**
  - With no request, stay in IDLE.
  - With any request, pick the owner:
    - A single requester wins.
    - If both request, the one not granted last wins.
  - Latch the owner's addr, wen, wdata and wmask into the request registers. For IFU, wen=0, wdata=0 and wmask=0.
  - Update `last_grant` and go to REQ.
- **REQ**
  - `o_mem_valid`=1; the `o_mem_*` fields are driven from the latched registers.
  - When `i_mem_ready`=1, pulse the owner's `o_*_gnt` combinationally in that same cycle, clear the timeout counter, and go to RESP.
  - With no ready, wait indefinitely; there is no timeout in REQ.
- **RESP**
  - `o_mem_valid`=0.
  - When `i_mem_rvalid`=1, the owner's `o_*_rvalid`=1 and `o_*_rdata`=`i_mem_rdata` (combinational pass-through); go to IDLE.
  - Otherwise increment the counter. When TIMEOUT≠0 and the counter reaches TIMEOUT−1 with no rvalid, in that cycle:
    - pulse `o_err`;
    - pulse the owner's `o_*_rvalid` with rdata=0;
    - go to IDLE.
- Requests arriving while not in IDLE are ignored. Requesters keep `req` asserted until they receive `gnt`.
- The non-owner's rvalid and gnt are 0 and its rdata is 0 at all times.
- `i_mem_rvalid` outside RESP is ignored.
- `i_mem_ready` outside REQ is ignored.
- Reset:
  - Any state goes to IDLE.
  - Request registers and counter are cleared.
  - `last_grant`=IFU, so the LSU wins the first conflict.
  - All outputs are 0.
  - An in-flight transaction is dropped with no rvalid.

## Timing
- Arbitration is registered.
  - Request sampled in IDLE at cycle N.
  - `o_mem_valid` at N+1.
  - Earliest gnt at N+1.
  - Earliest rvalid at N+2.
  - IDLE again at N+3.
- Minimum back-to-back transaction period is 3 cycles.
- With TIMEOUT=T, entering RESP at cycle M and no rvalid: `o_err` and rvalid at M+T−1, IDLE at M+T.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins, with real data and no `o_err`.

## Test plan
- IFU-only read:
  - Stimulus: `i_ifu_req`=1, addr 0x80000000; memory ready immediately; rdata 0x00000413 on the next cycle.
  - Required: `o_mem_valid`/addr at N+1, `o_ifu_gnt` at N+1, `o_ifu_rvalid` with 0x00000413 at N+2, `o_busy` low at N+3.
- LSU write:
  - Stimulus: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; `i_mem_ready` delayed 3 cycles.
  - Required: `o_mem_valid` held 4 cycles with stable fields, a single `o_lsu_gnt`, and `o_lsu_rvalid` on the ack.
- Conflict:
  - Stimulus: both requesters hold `req` continuously after reset.
  - Required: grants alternate LSU, IFU, LSU, IFU.
- Timeout:
  - Stimulus: TIMEOUT=4; memory accepts but never responds.
  - Required: `o_err` and `o_ifu_rvalid` with rdata 0 on the 4th RESP cycle, then IDLE.
- Reset mid-RESP:
  - Stimulus: `i_rst` asserted while in RESP.
  - Required: next cycle all outputs are 0 and `o_busy`=0; a late `i_mem_rvalid` produces no response; the next conflict is granted to the LSU.
